// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vid_pkg
//  Purpose  : Shared defaults, data types and FSM state encoding for the
//             VID SRAM read path.
//  Revision : 1.0  initial release
// ============================================================================
package vid_pkg;

  localparam int VID_BW     = 16;  // bits per VID
  localparam int Q          = 16;  // VIDs (lanes) per SRAM word
  localparam int ADDR_SPACE = 5;   // SRAM address width

  typedef logic [VID_BW-1:0]   vid_t;
  typedef logic [VID_BW*Q-1:0] vid_word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vid_word_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : vid_word_unpack
//  Purpose  : Selects one VID lane out of a packed SRAM word.
//             Lane 0 is the least significant VID_BW bits.
//  Revision : 1.0  initial release
// ============================================================================
module vid_word_unpack #(
  parameter int Q      = vid_pkg::Q,
  parameter int VID_BW = vid_pkg::VID_BW,
  parameter int LW     = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic [VID_BW*Q-1:0] word,
  input  logic [LW-1:0]       lane,
  output logic [VID_BW-1:0]   vid
);

  // Lane multiplexer; out-of-range lane indices return zero
  always_comb begin
    vid = '0;
    for (int i = 0; i < Q; i++) begin
      if (lane == LW'(i)) vid = word[i*VID_BW +: VID_BW];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vid_sram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : vid_sram_reader
//  Purpose  : Reads num_words consecutive SRAM words starting at base_addr
//             and streams their VIDs one per cycle on a valid/ready port.
//             The next word is prefetched while the current one streams.
//  Option   : VID_RD_STALL_CNT_EN adds the stall_cnt output (cycles with
//             vid_valid & ~vid_ready, saturating).
//  Revision : 1.0  initial release
// ============================================================================
module vid_sram_reader #(
  parameter int ADDR_SPACE = vid_pkg::ADDR_SPACE,
  parameter int Q          = vid_pkg::Q,
  parameter int VID_BW     = vid_pkg::VID_BW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_SPACE-1:0] base_addr,
  input  logic [ADDR_SPACE:0]   num_words,
  output logic [ADDR_SPACE-1:0] raddr,
  input  logic [VID_BW*Q-1:0]   rdata,
  output logic [VID_BW-1:0]     vid_out,
  output logic                  vid_valid,
  input  logic                  vid_ready,
  output logic                  vid_last,
  output logic                  busy,
  output logic                  done
`ifdef VID_RD_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  import vid_pkg::*;

  localparam int LW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(Q - 1);

  state_t                  state, state_nxt;
  logic [VID_BW*Q-1:0]     cur_word, pf_word;
  logic                    cur_valid, pf_valid;
  logic [LW-1:0]           lane;
  logic [ADDR_SPACE-1:0]   addr_next;    // next word address to fetch
  logic [ADDR_SPACE:0]     fetch_left;   // words not yet requested from SRAM
  logic [ADDR_SPACE:0]     words_left;   // words not yet fully streamed (incl. current)
  logic                    rd_pend;      // prefetch address is on raddr this cycle
  logic                    rd_wait;      // prefetch data is on rdata this cycle
  logic                    xfer, last_lane, final_word, swap, issue;
  logic [VID_BW-1:0]       lane_vid;

  vid_word_unpack #(.Q(Q), .VID_BW(VID_BW), .LW(LW)) u_unpack (
    .word (cur_word),
    .lane (lane),
    .vid  (lane_vid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode, handshake qualifiers and streaming outputs
  always_comb begin
    state_nxt  = state;
    vid_valid  = (state == STREAM) && cur_valid;
    xfer       = vid_valid && vid_ready;
    last_lane  = (lane == LANE_MAX);
    final_word = (words_left == (ADDR_SPACE+1)'(1));
    swap       = xfer && last_lane && !final_word;
    issue      = (state == STREAM) && (fetch_left != '0) && !pf_valid && !rd_pend && !rd_wait;
    vid_out    = vid_valid ? lane_vid : '0;
    vid_last   = vid_valid && last_lane && final_word;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? DONE : FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = STREAM;
      STREAM:  if (xfer && last_lane && final_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/word bookkeeping and the current/prefetch word buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr      <= '0;
      addr_next  <= '0;
      fetch_left <= '0;
      words_left <= '0;
      lane       <= '0;
      cur_word   <= '0;
      pf_word    <= '0;
      cur_valid  <= 1'b0;
      pf_valid   <= 1'b0;
      rd_pend    <= 1'b0;
      rd_wait    <= 1'b0;
    end else begin
      rd_pend <= issue;
      rd_wait <= rd_pend;
      case (state)
        IDLE: begin
          // Zero-length requests leave the SRAM address untouched
          if (start && (num_words != '0)) begin
            raddr      <= base_addr;
            addr_next  <= base_addr + 1'b1;
            fetch_left <= num_words - 1'b1;
            words_left <= num_words;
            lane       <= '0;
          end
        end
        WAIT: begin
          cur_word  <= rdata;
          cur_valid <= 1'b1;
        end
        STREAM: begin
          if (issue) begin
            raddr      <= addr_next;
            addr_next  <= addr_next + 1'b1;
            fetch_left <= fetch_left - 1'b1;
          end
          if (xfer) lane <= last_lane ? '0 : lane + 1'b1;
          if (swap) begin
            // Word boundary: promote prefetch, or fall back to the in-flight read
            words_left <= words_left - 1'b1;
            pf_valid   <= 1'b0;
            if (pf_valid) begin
              cur_word  <= pf_word;
              cur_valid <= 1'b1;
            end else if (rd_wait) begin
              cur_word  <= rdata;
              cur_valid <= 1'b1;
            end else begin
              cur_valid <= 1'b0;
            end
          end else if (rd_wait) begin
            if (cur_valid) begin
              pf_word  <= rdata;
              pf_valid <= 1'b1;
            end else begin
              cur_word  <= rdata;
              cur_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          cur_valid <= 1'b0;
          pf_valid  <= 1'b0;
          lane      <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef VID_RD_STALL_CNT_EN
  // Saturating count of back-pressured cycles for the current request
  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt <= '0;
    else if ((state == IDLE) && start)    stall_cnt <= '0;
    else if (vid_valid && !vid_ready && (stall_cnt != 16'hFFFF))
                                          stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vid_sram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_sram_reader
//  Purpose  : Self-checking bench for vid_sram_reader with an SRAM model
//             (registered read, #1 output delay) and a behavioural stream
//             model built from the request parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vid_sram_reader;

  import vid_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [ADDR_SPACE-1:0] base_addr;
  logic [ADDR_SPACE:0]   num_words;
  logic [ADDR_SPACE-1:0] raddr;
  vid_word_t             rdata;
  vid_t                  vid_out;
  logic                  vid_valid;
  logic                  vid_ready = 1'b1;
  logic                  vid_last;
  logic                  busy;
  logic                  done;
`ifdef VID_RD_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  vid_sram_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .raddr     (raddr),
    .rdata     (rdata),
    .vid_out   (vid_out),
    .vid_valid (vid_valid),
    .vid_ready (vid_ready),
    .vid_last  (vid_last),
    .busy      (busy),
    .done      (done)
`ifdef VID_RD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: address registered on posedge, data appears #1 later
  vid_word_t             mem [2**ADDR_SPACE];
  logic [ADDR_SPACE-1:0] ra;
  always @(posedge clk) begin
    ra = raddr;
    #1 rdata = mem[ra];
  end

  int   vectors = 0;
  int   errors  = 0;
  bit   rnd_mode = 1'b0;

  function automatic void check(input bit ok, input string name, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // Downstream ready: always 1, or 50% random
  initial begin
    forever begin
      @(posedge clk);
      #1 vid_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- behavioural model ----------------
  vid_t exp_q[$];
  vid_t got[$];
  bit   active = 1'b0;
  int   idx, total, cyc = 0, start_cyc, last_xfer_cyc, stalls;
  bit   first_seen, prev_stall;
  vid_t prev_vid;
  logic [ADDR_SPACE-1:0] raddr_at_start;
  logic [ADDR_SPACE:0]   req_num;

  // Compare process: one pass per cycle on the falling edge
  always @(negedge clk) begin
    bit accept, exp_done;
    cyc++;
    if (rst) begin
      active     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      accept   = start && !active;
      exp_done = active && ((total == 0 && cyc == start_cyc + 1) ||
                            (total > 0 && idx == total && cyc == last_xfer_cyc + 1));
      check(done == exp_done, "done", done, exp_done);
      check(busy == active, "busy", busy, active);
      if (vid_valid) begin
        if (!active || idx >= total) begin
          check(1'b0, "spurious_valid", vid_valid, 0);
        end else begin
          check(vid_out == exp_q[idx], "vid_out", vid_out, exp_q[idx]);
          check(vid_last == (idx == total - 1), "vid_last", vid_last, idx == total - 1);
          if (!first_seen) begin
            check(cyc == start_cyc + 3, "first_latency", cyc - start_cyc, 3);
            first_seen = 1'b1;
          end
          if (prev_stall) check(vid_out == prev_vid, "hold_stable", vid_out, prev_vid);
          if (vid_ready) begin
            got.push_back(vid_out);
            idx++;
            if (idx == total) last_xfer_cyc = cyc;
          end
        end
      end else begin
        if (prev_stall) check(1'b0, "valid_dropped", 0, 1);
        if (active && first_seen && idx < total) check(1'b0, "valid_gap", idx, total);
        if (vid_last) check(1'b0, "last_without_valid", 1, 0);
      end
      if (active && vid_valid && !vid_ready) stalls++;
      prev_stall = vid_valid && !vid_ready;
      prev_vid   = vid_out;
      if (exp_done) begin
`ifdef VID_RD_STALL_CNT_EN
        check(stall_cnt == 16'(stalls), "stall_cnt", stall_cnt, stalls);
`endif
        if (req_num == 0) check(raddr == raddr_at_start, "raddr_num0", raddr, raddr_at_start);
        active = 1'b0;
      end
      if (accept) begin
        exp_q.delete();
        got.delete();
        for (int w = 0; w < int'(num_words); w++) begin
          logic [ADDR_SPACE-1:0] a;
          a = base_addr + ADDR_SPACE'(w);
          for (int i = 0; i < Q; i++) exp_q.push_back(mem[a][i*VID_BW +: VID_BW]);
        end
        req_num        = num_words;
        total          = exp_q.size();
        idx            = 0;
        start_cyc      = cyc;
        first_seen     = 1'b0;
        stalls         = 0;
        raddr_at_start = raddr;
        active         = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic vid_t got_at(input int k);
    return (k < got.size()) ? got[k] : 16'hDEAD;
  endfunction

  task automatic fill_pattern();
    for (int a = 0; a < 2**ADDR_SPACE; a++)
      for (int i = 0; i < Q; i++) mem[a][i*VID_BW +: VID_BW] = 16'((a << 8) | i);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 2**ADDR_SPACE; a++)
      for (int i = 0; i < Q; i++) mem[a][i*VID_BW +: VID_BW] = 16'($urandom);
  endtask

  task automatic pulse_start(input logic [ADDR_SPACE-1:0] b, input logic [ADDR_SPACE:0] n);
    @(posedge clk);
    #1 start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (!active) break;
    end
    if (k == budget) check(1'b0, "timeout", k, budget);
  endtask

  task automatic run(input logic [ADDR_SPACE-1:0] b, input logic [ADDR_SPACE:0] n);
    pulse_start(b, n);
    wait_idle(3000);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    check(raddr == '0, "reset_raddr", raddr, 0);
    check(vid_out == '0 && !vid_valid && !vid_last, "reset_stream", {vid_valid, vid_out}, 0);
    check(!busy && !done, "reset_ctrl", {busy, done}, 0);
    rst = 1'b0;

    // Single word
    run(5'd3, 6'd1);
    check(got.size() == 16, "t1_count", got.size(), 16);
    check(got_at(0) == 16'h0300, "t1_first", got_at(0), 16'h0300);
    check(got_at(15) == 16'h030F, "t1_last", got_at(15), 16'h030F);

    // Four words, back-to-back
    run(5'd0, 6'd4);
    check(got.size() == 64, "t2_count", got.size(), 64);
    check(got_at(16) == 16'h0100, "t2_word1", got_at(16), 16'h0100);
    check(got_at(63) == 16'h030F, "t2_end", got_at(63), 16'h030F);

    // Address wrap
    run(5'd30, 6'd4);
    check(got_at(0)  == 16'h1E00, "t3_w0", got_at(0),  16'h1E00);
    check(got_at(16) == 16'h1F00, "t3_w1", got_at(16), 16'h1F00);
    check(got_at(32) == 16'h0000, "t3_w2", got_at(32), 16'h0000);
    check(got_at(48) == 16'h0100, "t3_w3", got_at(48), 16'h0100);

    // Random back-pressure
    rnd_mode = 1'b1;
    run(5'd0, 6'd4);
    check(got.size() == 64, "t4_count", got.size(), 64);
    rnd_mode = 1'b0;

    // Zero-length request
    run(5'd9, 6'd0);

    // Full address space
    run(5'd17, 6'd32);
    check(got.size() == 512, "full_count", got.size(), 512);

    // Ignored mid-stream start, then reset mid-request
    pulse_start(5'd0, 6'd4);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; base_addr = 5'd10; num_words = 6'd2;
    @(posedge clk);
    #1 start = 1'b0;
    for (k = 0; k < 200 && idx < 20; k++) @(posedge clk);
    if (k == 200) check(1'b0, "t6_timeout", k, 200);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check(!vid_valid && !busy && !done, "t6_after_rst", {vid_valid, busy, done}, 0);
    run(5'd5, 6'd2);
    check(got_at(0) == 16'h0500 && got.size() == 32, "t6_restart", got_at(0), 16'h0500);

    // Randomized requests
    for (int r = 0; r < 8; r++) begin
      fill_random();
      rnd_mode = r[0];
      run(ADDR_SPACE'($urandom_range(0, 31)), 6'($urandom_range(0, 32)));
    end
    rnd_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
